// File: rtl/distance_filter.sv
// ---------------------------------------------------------------------------
// distance_filter
//   Moving-average filter over the last N = 2**AVG_LOG2 distance samples.
//   Samples are clamped to MAX_DIST before being stored.
//   Only full windows produce an output.
//   The output is registered and feeds the FM stage LUT address.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset_n        : asynchronous active-low reset
//   enable         : gates sample acceptance only
//   sample_valid   : a sample is present this cycle
//   sample         : raw unsigned distance sample
//   flush          : synchronous clear of window, sum and state
//   distance       : filtered distance (sum >> AVG_LOG2), held between updates
//   distance_valid : one-cycle pulse per accepted sample while the window is full
//   filled         : high while the window holds N valid samples
// ---------------------------------------------------------------------------
module distance_filter #(
  parameter int WIDTH    = 13,
  parameter int AVG_LOG2 = 4,
  parameter int MAX_DIST = 2000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             flush,
  output logic [WIDTH-1:0] distance,
  output logic             distance_valid,
  output logic             filled
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [WIDTH-1:0] MAX_DIST_W = WIDTH'(MAX_DIST);
  localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_RUNNING
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_fill_cnt;
  logic [CNT_W-1:0]      w_fill_cnt_next;
  logic [WIDTH-1:0]      r_buf [N];
  logic [AVG_LOG2-1:0]   r_wr_ptr;
  logic [SUM_W-1:0]      r_sum;
  logic                  r_acc_d;
  logic [WIDTH-1:0]      r_distance;
  logic                  r_distance_valid;
  logic                  r_filled;

  logic                  w_accept;
  logic [WIDTH-1:0]      w_clamped;
  logic [WIDTH-1:0]      w_oldest;
  logic [SUM_W-1:0]      w_sum_next;

  // flush wins over a same-cycle sample, so the sample is simply not accepted.
  assign w_accept  = enable && sample_valid && !flush;
  assign w_clamped = (sample > MAX_DIST_W) ? MAX_DIST_W : sample;
  assign w_oldest  = r_buf[r_wr_ptr];

  // The entry being overwritten is exactly the sample that leaves the window.
  // Before the window is full that entry is still zero from reset or flush.
  // The sum therefore never goes below zero.
  // It never exceeds N * MAX_DIST, which fits in SUM_W bits.
  assign w_sum_next = r_sum + SUM_W'(w_clamped) - SUM_W'(w_oldest);

  // ---------------------------------------------------------------------------
  // Window storage, pointer and running sum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_sum    <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_sum    <= '0;
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= w_clamped;
      r_wr_ptr        <= r_wr_ptr + 1'b1;  // natural wrap N-1 -> 0
      r_sum           <= w_sum_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Fill-state FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_fill_cnt <= '0;
      r_filled   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_cnt_next;
      r_filled   <= (w_state_next == S_RUNNING);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    if (flush) begin
      w_state_next    = S_EMPTY;
      w_fill_cnt_next = '0;
    end else if (w_accept) begin
      case (r_state)
        S_EMPTY: begin
          w_fill_cnt_next = CNT_W'(1);
          w_state_next    = (N_CNT == CNT_W'(1)) ? S_RUNNING : S_FILLING;
        end
        S_FILLING: begin
          w_fill_cnt_next = r_fill_cnt + 1'b1;
          if (r_fill_cnt + 1'b1 == N_CNT) begin
            w_state_next = S_RUNNING;
          end
        end
        default: begin
          // RUNNING: the count saturates at N and the state is sticky.
          w_state_next = S_RUNNING;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  // r_acc_d marks that the sum/state now visible came from an acceptance.
  // A flush in this cycle cancels that in-flight update.
  // distance keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_d          <= 1'b0;
      r_distance       <= '0;
      r_distance_valid <= 1'b0;
    end else begin
      r_acc_d <= w_accept;
      if (r_acc_d && (r_state == S_RUNNING) && !flush) begin
        r_distance       <= r_sum[AVG_LOG2 +: WIDTH];  // truncating divide by N
        r_distance_valid <= 1'b1;
      end else begin
        r_distance_valid <= 1'b0;
      end
    end
  end

  assign distance       = r_distance;
  assign distance_valid = r_distance_valid;
  assign filled         = r_filled;

endmodule

// File: tb/tb_distance_filter.sv
// Directed testbench for distance_filter.
// Inputs are driven, and outputs observed, 1 time unit after each falling edge.
module tb_distance_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [12:0] sample = '0;
  logic        flush = 1'b0;
  logic [12:0] distance;
  logic        distance_valid;
  logic        filled;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  distance_filter #(.WIDTH(13), .AVG_LOG2(4), .MAX_DIST(2000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .flush          (flush),
    .distance       (distance),
    .distance_valid (distance_valid),
    .filled         (filled)
  );

  always #5 clk = ~clk;

  // Each pulse spans one full cycle, so it is seen at exactly one falling edge.
  always @(negedge clk) if (distance_valid) pulse_cnt++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one sample for one cycle; returns at the t+1 observation point.
  task automatic send(input logic [12:0] v);
    enable       = 1'b1;
    sample_valid = 1'b1;
    sample       = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // thin formatter only; comparisons are made inline by callers
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
    errors++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (distance !== 13'd0)   chk("reset_distance", distance, 0);
    checks++; if (distance_valid !== 0) chk("reset_valid", distance_valid, 0);
    checks++; if (filled !== 0)         chk("reset_filled", filled, 0);
    reset_n = 1'b1;
    tick();
    $display("test_reset: distance=%0d valid=%0b filled=%0b", distance, distance_valid, filled);
  endtask

  task automatic test_fill();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) send(13'd1000);
    checks++; if (pulse_cnt - p0 !== 0) chk("fill_no_early_pulse", pulse_cnt - p0, 0);
    tick();
    checks++; if (filled !== 1'b1)         chk("fill_filled", filled, 1);
    checks++; if (distance_valid !== 1'b1) chk("fill_valid", distance_valid, 1);
    checks++; if (distance !== 13'd1000)   chk("fill_distance", distance, 1000);
    checks++; if (pulse_cnt - p0 !== 1)    chk("fill_one_pulse", pulse_cnt - p0, 1);
    $display("test_fill: distance=%0d pulses=%0d", distance, pulse_cnt - p0);
  endtask

  task automatic test_step();
    int p0;
    p0 = pulse_cnt;
    send(13'd1160);
    tick();
    checks++; if (distance !== 13'd1010)   chk("step_first", distance, 1010);
    checks++; if (distance_valid !== 1'b1) chk("step_first_valid", distance_valid, 1);
    for (int i = 0; i < 15; i++) send(13'd1160);
    tick();
    checks++; if (distance !== 13'd1160)   chk("step_final", distance, 1160);
    checks++; if (pulse_cnt - p0 !== 16)   chk("step_back_to_back_pulses", pulse_cnt - p0, 16);
    $display("test_step: distance=%0d pulses=%0d", distance, pulse_cnt - p0);
  endtask

  task automatic test_saturate();
    do_flush();
    for (int i = 0; i < 16; i++) send(13'd8191);
    tick();
    checks++; if (distance !== 13'd2000) chk("sat_8191", distance, 2000);
    send(13'd2001);
    tick();
    checks++; if (distance !== 13'd2000) chk("sat_2001", distance, 2000);
    // 32000 - 2000 + 1999 = 31999, and 31999 >> 4 = 1999
    send(13'd1999);
    tick();
    checks++; if (distance !== 13'd1999) chk("sat_1999_passes", distance, 1999);
    $display("test_saturate: distance=%0d", distance);
  endtask

  task automatic test_flush();
    int p0;
    send(13'd0);                 // in flight when flush arrives next cycle
    flush        = 1'b1;
    sample_valid = 1'b1;
    sample       = 13'd500;      // must be dropped
    tick();
    flush        = 1'b0;
    sample_valid = 1'b0;
    checks++; if (distance_valid !== 1'b0) chk("flush_suppress_valid", distance_valid, 0);
    checks++; if (distance !== 13'd1999)   chk("flush_hold_distance", distance, 1999);
    checks++; if (filled !== 1'b0)         chk("flush_filled", filled, 0);
    p0 = pulse_cnt;
    for (int i = 0; i < 15; i++) send(13'd100);
    tick();
    tick();
    checks++; if (pulse_cnt - p0 !== 0) chk("flush_refill_no_pulse", pulse_cnt - p0, 0);
    send(13'd100);
    tick();
    checks++; if (distance !== 13'd100) chk("flush_refill_distance", distance, 100);
    checks++; if (pulse_cnt - p0 !== 1) chk("flush_refill_pulse", pulse_cnt - p0, 1);
    $display("test_flush: distance=%0d filled=%0b", distance, filled);
  endtask

  task automatic test_pattern();
    do_flush();
    for (int i = 0; i < 16; i++) send(13'(i * 100));
    tick();
    checks++; if (distance !== 13'd750)    chk("pattern_distance", distance, 750);
    checks++; if (dut.r_wr_ptr !== 4'd0)   chk("pattern_wr_ptr_wrap", dut.r_wr_ptr, 0);
    $display("test_pattern: distance=%0d", distance);
  endtask

  task automatic test_enable();
    int p0;
    p0 = pulse_cnt;
    enable       = 1'b0;
    sample_valid = 1'b1;
    sample       = 13'd5;
    for (int i = 0; i < 5; i++) tick();
    sample_valid = 1'b0;
    tick();
    checks++; if (pulse_cnt - p0 !== 0)  chk("enable_no_pulse", pulse_cnt - p0, 0);
    checks++; if (distance !== 13'd750)  chk("enable_hold", distance, 750);
    // Accept 1500 over the oldest entry (0), then drop enable.
    // 12000 + 1500 = 13500, and 13500 >> 4 = 843.
    send(13'd1500);
    enable       = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    checks++; if (distance_valid !== 1'b1) chk("enable_inflight_valid", distance_valid, 1);
    checks++; if (distance !== 13'd843)    chk("enable_inflight_distance", distance, 843);
    $display("test_enable: distance=%0d", distance);
  endtask

  task automatic test_reset_mid();
    int p0;
    do_flush();
    for (int i = 0; i < 5; i++) send(13'd700);
    reset_n = 1'b0;              // asynchronous, between clock edges
    #1;
    checks++; if (distance !== 13'd0)   chk("midreset_distance", distance, 0);
    checks++; if (distance_valid !== 0) chk("midreset_valid", distance_valid, 0);
    checks++; if (filled !== 0)         chk("midreset_filled", filled, 0);
    tick();
    reset_n = 1'b1;
    tick();
    p0 = pulse_cnt;
    for (int i = 0; i < 15; i++) send(13'd300);
    tick();
    checks++; if (pulse_cnt - p0 !== 0) chk("midreset_first_ever", pulse_cnt - p0, 0);
    send(13'd300);
    tick();
    checks++; if (distance !== 13'd300) chk("midreset_refill", distance, 300);
    $display("test_reset_mid: distance=%0d", distance);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_step();
    test_saturate();
    test_flush();
    test_pattern();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
